// File: rtl/ssc_pkg.sv
// ssc_pkg: shared encodings for the multi-channel SSC master.
// Holds the one-hot frame states, transfer direction, TX source select and line levels.
package ssc_pkg;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_CMD     = 6'b000010,
    ST_DATA_WR = 6'b000100,
    ST_TURN    = 6'b001000,
    ST_DATA_RD = 6'b010000,
    ST_DONE    = 6'b100000
  } sscState_t;

  localparam logic DIR_WRITE = 1'b1;
  localparam logic DIR_READ  = 1'b0;

  localparam logic SEL_CMD  = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ssc_clk_div.sv
// ssc_clk_div: serial clock generator for the SSC master.
// While enabled, each phase of sclk lasts divider+1 CLK cycles. The first enabled cycle
// already issues a fall strobe so that the first bit starts without a dead phase.
// When disabled, the counter is cleared and sclk rests high.
module ssc_clk_div
  import ssc_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic                 sclk,
  output logic                 fallStb,
  output logic                 riseStb
);

  logic [DIV_WIDTH-1:0] cnt;

  assign fallStb = en && (cnt == '0) && (sclk == HIGH);
  assign riseStb = en && (cnt == '0) && (sclk == LOW);

  // Count down each phase; toggle sclk and reload when the phase expires.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt  <= '0;
      sclk <= HIGH;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= HIGH;
    end else if (cnt == '0) begin
      cnt  <= divider;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ssc_master_mc.sv
// ssc_master_mc: parametrised multi-channel SSC master.
// Shifts a command and then an optional write or read data field MSB-first on a shared
// serial line, with one active-low sync per channel. A frame is sequenced on the fall
// strobes of ssc_clk_div; read data is captured on its rise strobes.
// Optional build macro: SSC_TURNAROUND_EN inserts one idle sclk period (TURN) between the
// command and the data of read frames.
module ssc_master_mc
  import ssc_pkg::*;
#(
  parameter int CMD_WIDTH  = 5,
  parameter int DATA_WIDTH = 48,
  parameter int LEN_WIDTH  = 6,
  parameter int NUM_CH     = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sscGo,
  input  logic                  sscDir,
  input  logic [CH_W-1:0]       sscChannel,
  input  logic [CMD_WIDTH-1:0]  sscCommand,
  input  logic [LEN_WIDTH-1:0]  sscDataLength,
  input  logic [DIV_WIDTH-1:0]  sscDivider,
  input  logic [DATA_WIDTH-1:0] sscDataIn,
  output logic [DATA_WIDTH-1:0] sscDataOut,
  output logic                  sscBusy,
  output logic                  sscDone,
  output logic                  sscError,
  output logic                  sscClk,
  output logic [NUM_CH-1:0]     sscSync,
  output logic                  portDir,
  output logic                  sscDataPinOut,
  input  logic                  sscDataPinIn
);

  localparam int MAX_W = maxOf(CMD_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CH_W:0]        CH_LIMIT = NUM_CH[CH_W:0];
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]     CMD_CNT  = CNT_W'(CMD_WIDTH);

  sscState_t             state, nextState;
  logic                  dirReg;
  logic [CH_W-1:0]       chReg;
  logic [CMD_WIDTH-1:0]  cmdShift;
  logic [DATA_WIDTH-1:0] dataShift;
  logic [DATA_WIDTH-1:0] rxShift;
  logic [CNT_W-1:0]      lenReg;
  logic [CNT_W-1:0]      bitCnt;
  logic [DIV_WIDTH-1:0]  divReg;
  logic [LEN_WIDTH-1:0]  lenClamped;
  logic                  busy, divClk, fallStb, riseStb, chValid, txSel, txBit;

  assign chValid    = ({1'b0, sscChannel} < CH_LIMIT);
  assign lenClamped = (sscDataLength > LEN_MAX) ? LEN_MAX : sscDataLength;
  assign busy       = (state != ST_IDLE) && (state != ST_DONE);

  assign txSel = (nextState == ST_DATA_WR) ? SEL_DATA : SEL_CMD;
  assign txBit = (txSel == SEL_DATA) ? dataShift[DATA_WIDTH-1] : cmdShift[CMD_WIDTH-1];

  assign sscBusy = busy;
  assign sscDone = (state == ST_DONE);
  assign sscClk  = busy ? divClk : HIGH;
  assign sscSync = busy ? ~(NUM_CH'(1) << chReg) : {NUM_CH{HIGH}};
  assign portDir = ((state == ST_TURN) || (state == ST_DATA_RD)) ? LOW : HIGH;

  ssc_clk_div #(
    .DIV_WIDTH(DIV_WIDTH)
  ) uClkDiv (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .en      (busy),
    .divider (divReg),
    .sclk    (divClk),
    .fallStb (fallStb),
    .riseStb (riseStb)
  );

  // Frame state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: phases advance on the fall strobe that follows their last bit.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (sscGo && chValid) nextState = ST_CMD;
      end
      ST_CMD: begin
        if (fallStb && (bitCnt == CMD_CNT)) begin
          if (lenReg == '0) begin
            nextState = ST_DONE;
          end else if (dirReg == DIR_READ) begin
`ifdef SSC_TURNAROUND_EN
            nextState = ST_TURN;
`else
            nextState = ST_DATA_RD;
`endif
          end else begin
            nextState = ST_DATA_WR;
          end
        end
      end
      ST_DATA_WR: begin
        if (fallStb && (bitCnt == lenReg)) nextState = ST_DONE;
      end
      ST_TURN: begin
        if (fallStb) nextState = ST_DATA_RD;
      end
      ST_DATA_RD: begin
        if (fallStb && (bitCnt == lenReg)) nextState = ST_DONE;
      end
      ST_DONE: begin
        nextState = ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch the request, shift TX bits on falls, capture RX bits on rises.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dirReg        <= DIR_WRITE;
      chReg         <= '0;
      cmdShift      <= '0;
      dataShift     <= '0;
      rxShift       <= '0;
      lenReg        <= '0;
      bitCnt        <= '0;
      divReg        <= '0;
      sscDataOut    <= '0;
      sscError      <= 1'b0;
      sscDataPinOut <= LOW;
    end else begin
      sscError <= 1'b0;
      if ((state == ST_IDLE) && sscGo) begin
        if (chValid) begin
          dirReg    <= sscDir;
          chReg     <= sscChannel;
          cmdShift  <= sscCommand;
          dataShift <= sscDataIn << (DATA_WIDTH - int'(lenClamped));
          lenReg    <= CNT_W'(lenClamped);
          divReg    <= sscDivider;
          bitCnt    <= '0;
          rxShift   <= '0;
        end else begin
          sscError <= 1'b1;
        end
      end
      if (fallStb) begin
        if ((nextState == ST_CMD) || (nextState == ST_DATA_WR)) begin
          sscDataPinOut <= txBit;
          if (txSel == SEL_DATA) dataShift <= dataShift << 1;
          else                   cmdShift  <= cmdShift << 1;
        end
        if (nextState != state) bitCnt <= CNT_W'(1);
        else                    bitCnt <= bitCnt + CNT_W'(1);
      end
      if (riseStb && (state == ST_DATA_RD)) begin
        rxShift <= (rxShift << 1) | DATA_WIDTH'(sscDataPinIn);
      end
      if ((state == ST_DATA_RD) && (nextState == ST_DONE)) begin
        sscDataOut <= rxShift;
      end
    end
  end

endmodule

// File: tb/tb_ssc_master_mc.sv
// tb_ssc_master_mc: directed bench for the multi-channel SSC master.
// Built with NUM_CH=3 so that an out-of-range channel (3) fits on the 2-bit channel port.
module tb_ssc_master_mc;

  localparam int CMD_W  = 5;
  localparam int DATA_W = 48;
  localparam int LEN_W  = 6;
  localparam int NCH    = 3;
  localparam int DIV_W  = 8;
  localparam int LIMIT  = 3000;
`ifdef SSC_TURNAROUND_EN
  localparam int TURN_P = 1;
`else
  localparam int TURN_P = 0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              sscGo = 1'b0;
  logic              sscDir = 1'b0;
  logic [1:0]        sscChannel = '0;
  logic [CMD_W-1:0]  sscCommand = '0;
  logic [LEN_W-1:0]  sscDataLength = '0;
  logic [DIV_W-1:0]  sscDivider = '0;
  logic [DATA_W-1:0] sscDataIn = '0;
  logic [DATA_W-1:0] sscDataOut;
  logic              sscBusy, sscDone, sscError, sscClk, portDir, sscDataPinOut;
  logic [NCH-1:0]    sscSync;
  logic              sscDataPinIn = 1'b1;

  // Free-running system clock.
  always #5 CLK = ~CLK;

  ssc_master_mc #(
    .CMD_WIDTH(CMD_W), .DATA_WIDTH(DATA_W), .LEN_WIDTH(LEN_W), .NUM_CH(NCH), .DIV_WIDTH(DIV_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .sscGo(sscGo), .sscDir(sscDir), .sscChannel(sscChannel),
    .sscCommand(sscCommand), .sscDataLength(sscDataLength), .sscDivider(sscDivider),
    .sscDataIn(sscDataIn), .sscDataOut(sscDataOut), .sscBusy(sscBusy), .sscDone(sscDone),
    .sscError(sscError), .sscClk(sscClk), .sscSync(sscSync), .portDir(portDir),
    .sscDataPinOut(sscDataPinOut), .sscDataPinIn(sscDataPinIn)
  );

  int          total = 0;
  int          bad = 0;
  int          frameCycles, nFalls, dirLowCycles;
  logic [63:0] bits;
  bit          syncBad, aborted;
  logic        doneBusy, doneClk, afterDone;
  logic [NCH-1:0] doneSync;

  // Runs one frame: records cycles to sscDone, TX bits at each sclk fall, portDir-low
  // cycles, and acts as a slave driving read data right after each fall.
  task automatic applyStimulus(input logic dir, input logic [1:0] ch, input logic [CMD_W-1:0] cmd,
                               input logic [LEN_W-1:0] len, input logic [DIV_W-1:0] div,
                               input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] slave,
                               input bit disturb, input int resetAt);
    logic prevClk;
    int effLen, idx;
    logic [NCH-1:0] expSync;
    effLen = (int'(len) > DATA_W) ? DATA_W : int'(len);
    expSync = ~(NCH'(1) << ch);
    @(negedge CLK);
    sscDir = dir; sscChannel = ch; sscCommand = cmd; sscDataLength = len;
    sscDivider = div; sscDataIn = data; sscDataPinIn = 1'b1; sscGo = 1'b1;
    @(negedge CLK);
    sscGo = 1'b0;
    frameCycles = 0; nFalls = 0; dirLowCycles = 0; bits = '0;
    syncBad = 1'b0; aborted = 1'b0; prevClk = 1'b1;
    while (sscDone !== 1'b1 && frameCycles < LIMIT) begin
      if (sscClk === 1'b0 && prevClk === 1'b1) begin
        bits = {bits[62:0], sscDataPinOut};
        idx = nFalls - CMD_W - ((dir == 1'b0) ? TURN_P : 0);
        sscDataPinIn = (idx >= 0 && idx < effLen) ? slave[effLen-1-idx] : 1'b1;
        nFalls++;
        if (resetAt > 0 && nFalls == resetAt) begin
          #2 RST_N = 1'b0;
          #1 aborted = 1'b1;
          break;
        end
      end
      prevClk = sscClk;
      if (sscSync !== expSync) syncBad = 1'b1;
      if (portDir === 1'b0) dirLowCycles++;
      if (disturb && frameCycles == 5) begin
        sscGo = 1'b1; sscDir = ~dir; sscChannel = 2'd0; sscCommand = ~cmd;
        sscDataLength = 6'd3; sscDivider = 8'd5; sscDataIn = ~data;
      end
      if (disturb && frameCycles == 7) sscGo = 1'b0;
      @(negedge CLK);
      frameCycles++;
    end
    if (!aborted) begin
      doneBusy = sscBusy; doneClk = sscClk; doneSync = sscSync;
      @(negedge CLK);
      afterDone = sscDone;
    end
  endtask

  // Reset values while RST_N is held low.
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (sscBusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", sscBusy); end
    total++; if (sscDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", sscDone); end
    total++; if (sscError !== 1'b0) begin bad++; $display("[TB] FAIL reset_error: got %b want 0", sscError); end
    total++; if (sscClk !== 1'b1) begin bad++; $display("[TB] FAIL reset_clk: got %b want 1", sscClk); end
    total++; if (sscSync !== 3'b111) begin bad++; $display("[TB] FAIL reset_sync: got %b want 111", sscSync); end
    total++; if (portDir !== 1'b1) begin bad++; $display("[TB] FAIL reset_portdir: got %b want 1", portDir); end
    total++; if (sscDataPinOut !== 1'b0) begin bad++; $display("[TB] FAIL reset_pin: got %b want 0", sscDataPinOut); end
    total++; if (sscDataOut !== 48'h0) begin bad++; $display("[TB] FAIL reset_dataout: got %h want 0", sscDataOut); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Write frame CMD=15h, len 8, data A5, div 0, channel 2.
  task automatic test_write();
    applyStimulus(1'b1, 2'd2, 5'h15, 6'd8, 8'd0, 48'hA5, 48'h0, 1'b0, 0);
    total++; if (frameCycles !== 27) begin bad++; $display("[TB] FAIL write_cycles: got %0d want 27", frameCycles); end
    total++; if (bits[12:0] !== 13'h15A5) begin bad++; $display("[TB] FAIL write_bits: got %h want 15a5", bits[12:0]); end
    total++; if (nFalls !== 13) begin bad++; $display("[TB] FAIL write_falls: got %0d want 13", nFalls); end
    total++; if (syncBad !== 1'b0) begin bad++; $display("[TB] FAIL write_sync: got bad=%b want 0", syncBad); end
    total++; if (dirLowCycles !== 0) begin bad++; $display("[TB] FAIL write_portdir: got %0d want 0", dirLowCycles); end
    total++; if ({doneBusy, doneClk, doneSync} !== 5'b01111) begin bad++; $display("[TB] FAIL write_donestate: got %b want 01111", {doneBusy, doneClk, doneSync}); end
    total++; if (afterDone !== 1'b0) begin bad++; $display("[TB] FAIL write_donepulse: got %b want 0", afterDone); end
    total++; if (sscDataOut !== 48'h0) begin bad++; $display("[TB] FAIL write_dataout: got %h want 0", sscDataOut); end
  endtask

  // Read frame: slave returns C3A over 12 bits at div 3.
  task automatic test_read();
    applyStimulus(1'b0, 2'd1, 5'h0A, 6'd12, 8'd3, 48'hFFFF_FFFF_FFFF, 48'hC3A, 1'b0, 0);
    total++; if (frameCycles !== 1 + (17 + TURN_P) * 8) begin bad++; $display("[TB] FAIL read_cycles: got %0d want %0d", frameCycles, 1 + (17 + TURN_P) * 8); end
    total++; if (sscDataOut !== 48'h000000000C3A) begin bad++; $display("[TB] FAIL read_data: got %h want 000000000c3a", sscDataOut); end
    total++; if (dirLowCycles !== (12 + TURN_P) * 8) begin bad++; $display("[TB] FAIL read_portdir: got %0d want %0d", dirLowCycles, (12 + TURN_P) * 8); end
    total++; if (nFalls !== 17 + TURN_P) begin bad++; $display("[TB] FAIL read_falls: got %0d want %0d", nFalls, 17 + TURN_P); end
    total++; if (syncBad !== 1'b0) begin bad++; $display("[TB] FAIL read_sync: got bad=%b want 0", syncBad); end
  endtask

  // Command-only read frame: no data phase, read data register untouched.
  task automatic test_cmd_only();
    applyStimulus(1'b0, 2'd0, 5'h1F, 6'd0, 8'd1, 48'h0, 48'h5, 1'b0, 0);
    total++; if (frameCycles !== 21) begin bad++; $display("[TB] FAIL cmdonly_cycles: got %0d want 21", frameCycles); end
    total++; if (nFalls !== 5) begin bad++; $display("[TB] FAIL cmdonly_falls: got %0d want 5", nFalls); end
    total++; if (bits[4:0] !== 5'h1F) begin bad++; $display("[TB] FAIL cmdonly_bits: got %h want 1f", bits[4:0]); end
    total++; if (sscDataOut !== 48'h000000000C3A) begin bad++; $display("[TB] FAIL cmdonly_dataout: got %h want 000000000c3a", sscDataOut); end
    total++; if (dirLowCycles !== 0) begin bad++; $display("[TB] FAIL cmdonly_portdir: got %0d want 0", dirLowCycles); end
  endtask

  // Length clamp to 48 bits, and an invalid channel request.
  task automatic test_limits();
    applyStimulus(1'b1, 2'd0, 5'h0C, 6'd63, 8'd0, 48'hA5C3_0F96_1234, 48'h0, 1'b0, 0);
    total++; if (frameCycles !== 107) begin bad++; $display("[TB] FAIL clamp_cycles: got %0d want 107", frameCycles); end
    total++; if (nFalls !== 53) begin bad++; $display("[TB] FAIL clamp_falls: got %0d want 53", nFalls); end
    total++; if (bits[52:0] !== {5'h0C, 48'hA5C3_0F96_1234}) begin bad++; $display("[TB] FAIL clamp_bits: got %h want %h", bits[52:0], {5'h0C, 48'hA5C3_0F96_1234}); end
    @(negedge CLK);
    sscChannel = 2'd3; sscDir = 1'b1; sscDataLength = 6'd4; sscGo = 1'b1;
    @(negedge CLK);
    sscGo = 1'b0;
    total++; if (sscError !== 1'b1) begin bad++; $display("[TB] FAIL badch_error: got %b want 1", sscError); end
    total++; if (sscBusy !== 1'b0) begin bad++; $display("[TB] FAIL badch_busy: got %b want 0", sscBusy); end
    @(negedge CLK);
    total++; if ({sscError, sscBusy, sscSync} !== 5'b00111) begin bad++; $display("[TB] FAIL badch_after: got %b want 00111", {sscError, sscBusy, sscSync}); end
  endtask

  // Mid-frame sscGo and input changes, then a second frame straight afterwards.
  task automatic test_back_to_back();
    bit sawBusy;
    applyStimulus(1'b1, 2'd1, 5'h15, 6'd8, 8'd0, 48'hA5, 48'h0, 1'b1, 0);
    total++; if (frameCycles !== 27) begin bad++; $display("[TB] FAIL disturb_cycles: got %0d want 27", frameCycles); end
    total++; if (bits[12:0] !== 13'h15A5) begin bad++; $display("[TB] FAIL disturb_bits: got %h want 15a5", bits[12:0]); end
    total++; if (syncBad !== 1'b0) begin bad++; $display("[TB] FAIL disturb_sync: got bad=%b want 0", syncBad); end
    sawBusy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sscBusy !== 1'b0) sawBusy = 1'b1;
      @(negedge CLK);
    end
    total++; if (sawBusy !== 1'b0) begin bad++; $display("[TB] FAIL disturb_noframe: got busy=%b want 0", sawBusy); end
    applyStimulus(1'b1, 2'd0, 5'h03, 6'd4, 8'd2, 48'h9, 48'h0, 1'b0, 0);
    total++; if (frameCycles !== 55) begin bad++; $display("[TB] FAIL b2b_cycles: got %0d want 55", frameCycles); end
    total++; if (bits[8:0] !== 9'h039) begin bad++; $display("[TB] FAIL b2b_bits: got %h want 039", bits[8:0]); end
  endtask

  // Asynchronous reset during data bit 20 of a 48-bit write, then a clean frame.
  task automatic test_reset_midframe();
    applyStimulus(1'b1, 2'd0, 5'h15, 6'd48, 8'd0, 48'hFFFF_FFFF_FFFF, 48'h0, 1'b0, 26);
    total++; if (aborted !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_reached: got %b want 1", aborted); end
    total++; if ({sscBusy, sscDone, sscClk, portDir, sscDataPinOut} !== 5'b00110) begin bad++; $display("[TB] FAIL rstmid_outputs: got %b want 00110", {sscBusy, sscDone, sscClk, portDir, sscDataPinOut}); end
    total++; if (sscSync !== 3'b111) begin bad++; $display("[TB] FAIL rstmid_sync: got %b want 111", sscSync); end
    total++; if (sscDataOut !== 48'h0) begin bad++; $display("[TB] FAIL rstmid_dataout: got %h want 0", sscDataOut); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++; if ({sscBusy, sscDone} !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_release: got %b want 00", {sscBusy, sscDone}); end
    applyStimulus(1'b1, 2'd2, 5'h15, 6'd8, 8'd0, 48'hA5, 48'h0, 1'b0, 0);
    total++; if (frameCycles !== 27) begin bad++; $display("[TB] FAIL rstmid_rerun_cycles: got %0d want 27", frameCycles); end
    total++; if (bits[12:0] !== 13'h15A5) begin bad++; $display("[TB] FAIL rstmid_rerun_bits: got %h want 15a5", bits[12:0]); end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_write();
    test_read();
    test_cmd_only();
    test_limits();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
